// File: rtl/cache_pkg.sv
// Shared widths and FSM state encoding for the cache miss controller.
// Optional write-back support is enabled with CACHE_WRITEBACK_EN.
package cache_pkg;

  localparam int CACHE_ADDR_W   = 32;
  localparam int CACHE_TAG_W    = 28;
  localparam int CACHE_IDX_W    = 8;
  localparam int CACHE_OFFSET_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    UPDATE,
    RESPOND
  } state_t;

endpackage

// File: rtl/rr_victim_ptr.sv
// Round-robin victim pointer; wraps naturally at 2^W-1.
// Advances once per tag-store update.
module rr_victim_ptr
  import cache_pkg::*;
#(
  parameter int W = CACHE_IDX_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         advance,
  output logic [W-1:0] ptr
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Cache miss controller: lookup, optional write-back, refill, tag update.
// Define CACHE_WRITEBACK_EN for dirty tracking and the WRITEBACK state.
module cache_miss_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W   = CACHE_ADDR_W,
  parameter int TAG_W    = CACHE_TAG_W,
  parameter int IDX_W    = CACHE_IDX_W,
  parameter int OFFSET_W = CACHE_OFFSET_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic [TAG_W-1:0]  lookup_tag,
  input  logic              found,
  input  logic [IDX_W-1:0]  hit_index,
  input  logic [TAG_W-1:0]  replaced_tag,
  output logic              tag_update,
  output logic [IDX_W-1:0]  rep_ptr,
  output logic [IDX_W-1:0]  line_index,
  output logic              mem_req_valid,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  output logic              resp_valid
);

  localparam int LINES = 1 << IDX_W;

  state_t            state;
  state_t            next;
  logic [TAG_W-1:0]  tag_q;
  logic              write_q;
  logic [LINES-1:0]  valid_bits;
  logic              hit;
  logic              wb_needed;
  logic              unused_bits;

  assign hit = found && valid_bits[hit_index];

  assign req_ready     = (state == IDLE);
  assign lookup_tag    = (state == IDLE) ? '0 : tag_q;
  assign tag_update    = (state == UPDATE);
  assign resp_valid    = (state == RESPOND);
  assign mem_req_valid = (state == WRITEBACK) || (state == REFILL);

`ifdef CACHE_WRITEBACK_EN
  logic [LINES-1:0] dirty_bits;

  assign wb_needed     = valid_bits[rep_ptr] && dirty_bits[rep_ptr];
  assign mem_req_write = (state == WRITEBACK);
  assign unused_bits   = ^req_addr[OFFSET_W-1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      dirty_bits <= '0;
    end else if (state == LOOKUP && hit && write_q) begin
      dirty_bits[hit_index] <= 1'b1;
    end else if (state == UPDATE) begin
      dirty_bits[rep_ptr] <= write_q;
    end
  end
`else
  assign wb_needed     = 1'b0;
  assign mem_req_write = 1'b0;
  assign unused_bits   = ^{req_addr[OFFSET_W-1:0], replaced_tag};
`endif

  rr_victim_ptr #(.W(IDX_W)) u_victim (
    .CLK     (CLK),
    .RST     (RST),
    .advance (state == UPDATE),
    .ptr     (rep_ptr)
  );

  always_comb begin
    next = state;
    unique case (state)
      IDLE:      if (req_valid) next = LOOKUP;
      LOOKUP: begin
        if (hit)            next = RESPOND;
        else if (wb_needed) next = WRITEBACK;
        else                next = REFILL;
      end
      WRITEBACK: if (mem_ready) next = REFILL;
      REFILL:    if (mem_ready) next = UPDATE;
      UPDATE:    next = RESPOND;
      RESPOND:   next = IDLE;
      default:   next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      tag_q      <= '0;
      write_q    <= 1'b0;
      valid_bits <= '0;
      mem_addr   <= '0;
      line_index <= '0;
    end else begin
      state <= next;
      if (state == IDLE && req_valid) begin
        tag_q   <= req_addr[ADDR_W-1:OFFSET_W];
        write_q <= req_write;
      end
      // mem_addr is registered so it cannot move while a request is held
      if (state == LOOKUP && hit) begin
        line_index <= hit_index;
      end else if (state == LOOKUP) begin
`ifdef CACHE_WRITEBACK_EN
        mem_addr <= wb_needed ? {replaced_tag, {OFFSET_W{1'b0}}}
                              : {tag_q, {OFFSET_W{1'b0}}};
`else
        mem_addr <= {tag_q, {OFFSET_W{1'b0}}};
`endif
      end
      if (state == WRITEBACK && mem_ready) begin
        mem_addr <= {tag_q, {OFFSET_W{1'b0}}};
      end
      if (state == REFILL && mem_ready) begin
        mem_addr <= '0;
      end
      if (state == UPDATE) begin
        valid_bits[rep_ptr] <= 1'b1;
        line_index          <= rep_ptr;
      end
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: cold miss, hit, write-back, stall, reset abort.
// Write-back expectations follow CACHE_WRITEBACK_EN.
module tb_cache_miss_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic [27:0] lookup_tag;
  logic        found = 1'b0;
  logic [7:0]  hit_index = '0;
  logic [27:0] replaced_tag = '0;
  logic        tag_update;
  logic [7:0]  rep_ptr;
  logic [7:0]  line_index;
  logic        mem_req_valid;
  logic        mem_req_write;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic        resp_valid;

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  cache_miss_ctrl dut (
    .CLK           (CLK),
    .RST           (RST),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .lookup_tag    (lookup_tag),
    .found         (found),
    .hit_index     (hit_index),
    .replaced_tag  (replaced_tag),
    .tag_update    (tag_update),
    .rep_ptr       (rep_ptr),
    .line_index    (line_index),
    .mem_req_valid (mem_req_valid),
    .mem_req_write (mem_req_write),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .resp_valid    (resp_valid)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic accept(input logic [31:0] a, input logic w);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    step();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic run_miss(input logic [31:0] a, output bit ok);
    found = 1'b0;
    accept(a, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mem_ready = mem_req_valid;
      step();
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    mem_ready = 1'b0;
    step();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    total++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", req_ready); else passed++;
    total++; if (mem_req_valid !== 1'b0) $display("FAIL rst_mem_valid got %b want 0", mem_req_valid); else passed++;
    total++; if (tag_update !== 1'b0) $display("FAIL rst_tag_update got %b want 0", tag_update); else passed++;
    total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp got %b want 0", resp_valid); else passed++;
    total++; if (rep_ptr !== 8'd0) $display("FAIL rst_rep_ptr got %h want 0", rep_ptr); else passed++;
    total++; if (mem_addr !== 32'd0) $display("FAIL rst_mem_addr got %h want 0", mem_addr); else passed++;
    total++; if (line_index !== 8'd0) $display("FAIL rst_line got %h want 0", line_index); else passed++;
    RST = 1'b0;
    step();
  endtask

  task automatic test_cold_miss();
    found = 1'b1;
    hit_index = 8'd0;
    accept(32'h0000_0040, 1'b0);
    total++; if (lookup_tag !== 28'h4) $display("FAIL cold_lookup_tag got %h want 4", lookup_tag); else passed++;
    step();
    total++; if (mem_req_valid !== 1'b1) $display("FAIL cold_refill_valid got %b want 1", mem_req_valid); else passed++;
    total++; if (mem_req_write !== 1'b0) $display("FAIL cold_refill_write got %b want 0", mem_req_write); else passed++;
    total++; if (mem_addr !== 32'h0000_0040) $display("FAIL cold_refill_addr got %h want 00000040", mem_addr); else passed++;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    total++; if (tag_update !== 1'b1) $display("FAIL cold_tag_update got %b want 1", tag_update); else passed++;
    total++; if (rep_ptr !== 8'd0) $display("FAIL cold_update_ptr got %h want 0", rep_ptr); else passed++;
    step();
    total++; if (resp_valid !== 1'b1) $display("FAIL cold_resp got %b want 1", resp_valid); else passed++;
    total++; if (line_index !== 8'd0) $display("FAIL cold_line got %h want 0", line_index); else passed++;
    total++; if (rep_ptr !== 8'd1) $display("FAIL cold_ptr_after got %h want 1", rep_ptr); else passed++;
    step();
  endtask

  task automatic test_hit();
    found = 1'b1;
    hit_index = 8'd0;
    mem_ready = 1'b1;
    accept(32'h0000_0040, 1'b0);
    total++; if (resp_valid !== 1'b0) $display("FAIL hit_early_resp got %b want 0", resp_valid); else passed++;
    step();
    total++; if (resp_valid !== 1'b1) $display("FAIL hit_resp got %b want 1", resp_valid); else passed++;
    total++; if (line_index !== 8'd0) $display("FAIL hit_line got %h want 0", line_index); else passed++;
    total++; if (mem_req_valid !== 1'b0) $display("FAIL hit_mem_valid got %b want 0", mem_req_valid); else passed++;
    mem_ready = 1'b0;
    step();
    total++; if (req_ready !== 1'b1) $display("FAIL hit_idle got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_writeback();
    bit ok;
    bit all_ok = 1'b1;
    found = 1'b1;
    hit_index = 8'd0;
    accept(32'h0000_0040, 1'b1);
    step();
    total++; if (resp_valid !== 1'b1) $display("FAIL wrhit_resp got %b want 1", resp_valid); else passed++;
    step();
    for (int i = 0; i < 255; i++) begin
      run_miss(32'h0001_0000 + 32'(i) * 32'h10, ok);
      all_ok &= ok;
    end
    total++; if (all_ok !== 1'b1) $display("FAIL fill_timeout got %b want 1", all_ok); else passed++;
    total++; if (rep_ptr !== 8'd0) $display("FAIL fill_ptr got %h want 0", rep_ptr); else passed++;
    found = 1'b0;
    replaced_tag = 28'h000_0004;
    accept(32'h0000_1000, 1'b0);
    step();
`ifdef CACHE_WRITEBACK_EN
    total++; if (mem_req_valid !== 1'b1) $display("FAIL wb_valid got %b want 1", mem_req_valid); else passed++;
    total++; if (mem_req_write !== 1'b1) $display("FAIL wb_write got %b want 1", mem_req_write); else passed++;
    total++; if (mem_addr !== 32'h0000_0040) $display("FAIL wb_addr got %h want 00000040", mem_addr); else passed++;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
`endif
    total++; if (mem_req_valid !== 1'b1) $display("FAIL miss_refill_valid got %b want 1", mem_req_valid); else passed++;
    total++; if (mem_req_write !== 1'b0) $display("FAIL miss_refill_write got %b want 0", mem_req_write); else passed++;
    total++; if (mem_addr !== 32'h0000_1000) $display("FAIL miss_refill_addr got %h want 00001000", mem_addr); else passed++;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    total++; if (resp_valid !== 1'b1) $display("FAIL miss_resp got %b want 1", resp_valid); else passed++;
    total++; if (line_index !== 8'd0) $display("FAIL miss_line got %h want 0", line_index); else passed++;
    step();
  endtask

  task automatic test_stall();
    int tu = 0;
    found = 1'b0;
    accept(32'h0000_2000, 1'b0);
    step();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_2000)
        $display("FAIL stall_hold[%0d] got valid=%b addr=%h want 1/00002000", i, mem_req_valid, mem_addr);
      else passed++;
      tu += int'(tag_update);
      step();
    end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    tu += int'(tag_update);
    step();
    tu += int'(tag_update);
    total++; if (resp_valid !== 1'b1) $display("FAIL stall_resp got %b want 1", resp_valid); else passed++;
    total++; if (line_index !== 8'd1) $display("FAIL stall_line got %h want 1", line_index); else passed++;
    total++; if (tu !== 1) $display("FAIL stall_tag_updates got %0d want 1", tu); else passed++;
    step();
  endtask

  task automatic test_reset_abort();
    bit seen = 1'b0;
    found = 1'b0;
    accept(32'h0000_3000, 1'b0);
    step();
    total++; if (mem_req_valid !== 1'b1) $display("FAIL abort_refill got %b want 1", mem_req_valid); else passed++;
    step();
    RST = 1'b1;
    step();
    total++; if (mem_req_valid !== 1'b0) $display("FAIL abort_mem_valid got %b want 0", mem_req_valid); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL abort_ready got %b want 1", req_ready); else passed++;
    total++; if (rep_ptr !== 8'd0) $display("FAIL abort_ptr got %h want 0", rep_ptr); else passed++;
    seen |= resp_valid;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      seen |= resp_valid;
    end
    total++; if (seen !== 1'b0) $display("FAIL abort_resp got %b want 0", seen); else passed++;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_writeback();
    test_stall();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cache_miss_ctrl.md
CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: request/memory address width.
REQ-002 SHALL have parameter TAG_W, default 28: tag width, equal to ADDR_W-OFFSET_W.
REQ-003 SHALL have parameter IDX_W, default 8: line index width (2^IDX_W lines).
REQ-004 SHALL have parameter OFFSET_W, default 4: line offset width.
REQ-005 SHALL have the port CLK, input, 1: the single clock; all logic on the rising edge.
REQ-006 SHALL have the port RST, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have the ports req_valid, input, 1 and req_write, input, 1 and req_addr, input, ADDR_W: the CPU request.
REQ-008 SHALL have the port req_ready, output, 1: request accepted when req_valid&&req_ready.
REQ-009 SHALL have the port lookup_tag, output, TAG_W: the tag-store search/write tag.
REQ-010 SHALL have the ports found, input, 1 and hit_index, input, IDX_W and replaced_tag, input, TAG_W: the tag-store results.
REQ-011 SHALL have the ports tag_update, output, 1 and rep_ptr, output, IDX_W: the tag-store write strobe and victim pointer.
REQ-012 SHALL have the port line_index, output, IDX_W: the data-array line, valid while resp_valid.
REQ-013 SHALL have the ports mem_req_valid, output, 1 and mem_req_write, output, 1 and mem_addr, output, ADDR_W and mem_ready, input, 1: the backing-memory handshake.
REQ-014 SHALL have the port resp_valid, output, 1: a one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, LOOKUP, WRITEBACK, REFILL, UPDATE, RESPOND.
REQ-016 SHALL drive req_ready=1 only in IDLE; on accept, latch req_addr and req_write, then go to LOOKUP.
REQ-017 SHALL drive lookup_tag=latched_addr[ADDR_W-1:OFFSET_W] in all non-IDLE states.
REQ-018 SHALL, in LOOKUP, treat the request as a hit iff found && valid_bit[hit_index]; a hit goes to RESPOND with line_index=hit_index and, on a write, sets dirty_bit[hit_index].
REQ-019 SHALL, in LOOKUP on a miss, go to WRITEBACK if valid_bit[rep_ptr]&&dirty_bit[rep_ptr], else to REFILL.
REQ-020 SHALL, in WRITEBACK, hold mem_req_valid=1, mem_req_write=1 and mem_addr={replaced_tag,OFFSET_W'0} until mem_ready, then go to REFILL.
REQ-021 SHALL, in REFILL, hold mem_req_valid=1, mem_req_write=0 and mem_addr={lookup_tag,OFFSET_W'0} until mem_ready, then go to UPDATE.
REQ-022 SHALL, in UPDATE, pulse tag_update=1 for exactly one cycle, set valid_bit[rep_ptr]=1 and dirty_bit[rep_ptr]=req_write, and set line_index=rep_ptr; rep_ptr increments on that edge, then go to RESPOND.
REQ-023 SHALL, in RESPOND, assert resp_valid for one cycle, then return to IDLE.
REQ-024 SHALL give a hit fixed latency: accept at edge N, resp_valid high in the cycle after edge N+1 (two cycles).
REQ-025 SHALL wrap rep_ptr round-robin from 2^IDX_W-1 to 0; rep_ptr changes only in UPDATE.
REQ-026 SHALL ignore mem_ready while mem_req_valid=0, and SHALL keep mem_addr and mem_req_write stable while mem_req_valid=1.
REQ-027 SHALL never assert tag_update outside UPDATE, and SHALL keep it low in the cycle a new request is accepted.

Reset
REQ-028 SHALL, on RST, set state=IDLE, rep_ptr=0, all valid/dirty bits=0, and tag_update, mem_req_valid, mem_req_write, resp_valid=0, mem_addr=0 and line_index=0.
REQ-029 SHALL have RST mid-transaction abort it: mem_req_valid=0 from the first cycle after the reset edge, with no response issued.

Configuration
REQ-030 SHALL, with CACHE_WRITEBACK_EN defined, implement dirty tracking and the WRITEBACK state as above.
REQ-031 SHALL, without CACHE_WRITEBACK_EN, omit dirty bits, never enter WRITEBACK (misses go directly to REFILL), and tie mem_req_write=0.

Structure
REQ-032 SHALL place ADDR_W/TAG_W/IDX_W/OFFSET_W defaults and the FSM state enum in shared package cache_pkg.
REQ-033 SHALL implement the round-robin victim counter as sub-module rr_victim_ptr (inputs: CLK, RST, advance; output: ptr).

Verification
REQ-034 SHALL cover: cold read 0x0000_0040 after reset, found=1 with hit_index=0 -> treated as miss; REFILL at mem_addr 0x0000_0040, tag_update with rep_ptr=0, resp_valid with line_index=0, rep_ptr becomes 1.
REQ-035 SHALL cover: repeat read 0x0000_0040 with found=1, hit_index=0 -> resp_valid two cycles after accept, line_index=0, no mem_req_valid.
REQ-036 SHALL cover: write hit on line 0, then force rep_ptr back to 0 via 255 further refills, then miss 0x0000_1000 with replaced_tag=0x0000004 -> WRITEBACK at mem_addr 0x0000_0040, then REFILL at 0x0000_1000 (WRITEBACK only when CACHE_WRITEBACK_EN is defined).
REQ-037 SHALL cover: mem_ready held low for 10 cycles during REFILL -> mem_addr and mem_req_valid stable throughout, exactly one tag_update afterward.
REQ-038 SHALL cover: RST asserted in the cycle after REFILL starts -> next cycle mem_req_valid=0, req_ready=1, rep_ptr=0, no resp_valid.
